// File: rtl/dds_pkg.sv
// Shared constants and the quarter-wave sine table for the DDS.
package dds_pkg;

  // Sine lookup is addressed by the top 8 phase bits.
  localparam int LUT_ADDR_W = 8;
  // Quarter-wave table covers i = 0..64 inclusive so the peak is exact.
  localparam int QUARTER_LEN = 65;
  // Quarter-wave magnitudes fit in 7 bits (max 127).
  localparam int MAG_W = 7;
  // Offset-binary zero level.
  localparam logic [7:0] OFFSET = 8'h80;

  // Quadrant of the full-wave index k[7:6].
  typedef enum logic [1:0] {
    QUAD_POS_UP   = 2'd0,  // +Q[i]
    QUAD_POS_DOWN = 2'd1,  // +Q[64-i]
    QUAD_NEG_UP   = 2'd2,  // -Q[i]
    QUAD_NEG_DOWN = 2'd3   // -Q[64-i]
  } quadrant_e;

  // Q[i] = round(127*sin(2*pi*i/256)), i = 0..64.
  function automatic logic [MAG_W-1:0] quarter_sine(input logic [MAG_W-1:0] idx);
    case (idx)
      7'd0:  quarter_sine = 7'd0;
      7'd1:  quarter_sine = 7'd3;
      7'd2:  quarter_sine = 7'd6;
      7'd3:  quarter_sine = 7'd9;
      7'd4:  quarter_sine = 7'd12;
      7'd5:  quarter_sine = 7'd16;
      7'd6:  quarter_sine = 7'd19;
      7'd7:  quarter_sine = 7'd22;
      7'd8:  quarter_sine = 7'd25;
      7'd9:  quarter_sine = 7'd28;
      7'd10: quarter_sine = 7'd31;
      7'd11: quarter_sine = 7'd34;
      7'd12: quarter_sine = 7'd37;
      7'd13: quarter_sine = 7'd40;
      7'd14: quarter_sine = 7'd43;
      7'd15: quarter_sine = 7'd46;
      7'd16: quarter_sine = 7'd49;
      7'd17: quarter_sine = 7'd51;
      7'd18: quarter_sine = 7'd54;
      7'd19: quarter_sine = 7'd57;
      7'd20: quarter_sine = 7'd60;
      7'd21: quarter_sine = 7'd63;
      7'd22: quarter_sine = 7'd65;
      7'd23: quarter_sine = 7'd68;
      7'd24: quarter_sine = 7'd71;
      7'd25: quarter_sine = 7'd73;
      7'd26: quarter_sine = 7'd76;
      7'd27: quarter_sine = 7'd78;
      7'd28: quarter_sine = 7'd81;
      7'd29: quarter_sine = 7'd83;
      7'd30: quarter_sine = 7'd85;
      7'd31: quarter_sine = 7'd88;
      7'd32: quarter_sine = 7'd90;
      7'd33: quarter_sine = 7'd92;
      7'd34: quarter_sine = 7'd94;
      7'd35: quarter_sine = 7'd96;
      7'd36: quarter_sine = 7'd98;
      7'd37: quarter_sine = 7'd100;
      7'd38: quarter_sine = 7'd102;
      7'd39: quarter_sine = 7'd104;
      7'd40: quarter_sine = 7'd106;
      7'd41: quarter_sine = 7'd107;
      7'd42: quarter_sine = 7'd109;
      7'd43: quarter_sine = 7'd111;
      7'd44: quarter_sine = 7'd112;
      7'd45: quarter_sine = 7'd113;
      7'd46: quarter_sine = 7'd115;
      7'd47: quarter_sine = 7'd116;
      7'd48: quarter_sine = 7'd117;
      7'd49: quarter_sine = 7'd118;
      7'd50: quarter_sine = 7'd120;
      7'd51: quarter_sine = 7'd121;
      7'd52: quarter_sine = 7'd122;
      7'd53: quarter_sine = 7'd122;
      7'd54: quarter_sine = 7'd123;
      7'd55: quarter_sine = 7'd124;
      7'd56: quarter_sine = 7'd125;
      7'd57: quarter_sine = 7'd125;
      7'd58: quarter_sine = 7'd126;
      7'd59: quarter_sine = 7'd126;
      7'd60: quarter_sine = 7'd126;
      7'd61: quarter_sine = 7'd127;
      7'd62: quarter_sine = 7'd127;
      7'd63: quarter_sine = 7'd127;
      7'd64: quarter_sine = 7'd127;
      // Indices above 64 never occur; hold the peak for safety.
      default: quarter_sine = 7'd127;
    endcase
  endfunction

endpackage

// File: rtl/dds_sine_rom.sv
// Combinational full-wave sine lookup built from the quarter-wave table.
// The 8-bit index is split into quadrant k[7:6] and offset k[5:0]; the
// quadrant selects mirroring (64-i) and negation around the 0x80 midpoint.
module dds_sine_rom
  import dds_pkg::*;
(
  input  logic [LUT_ADDR_W-1:0] i_addr,
  output logic [7:0]            o_sample
);

  quadrant_e        w_quad;
  logic [5:0]       w_fine;
  logic             w_mirror;
  logic             w_negate;
  logic [MAG_W-1:0] w_idx;
  logic [MAG_W-1:0] w_mag;
  logic [8:0]       w_sum;

  assign w_quad = quadrant_e'(i_addr[7:6]);
  assign w_fine = i_addr[5:0];

  // Decode the quadrant into mirror / negate controls.
  always_comb begin
    w_mirror = 1'b0;
    w_negate = 1'b0;
    case (w_quad)
      QUAD_POS_UP:   begin w_mirror = 1'b0; w_negate = 1'b0; end
      QUAD_POS_DOWN: begin w_mirror = 1'b1; w_negate = 1'b0; end
      QUAD_NEG_UP:   begin w_mirror = 1'b0; w_negate = 1'b1; end
      QUAD_NEG_DOWN: begin w_mirror = 1'b1; w_negate = 1'b1; end
    endcase
  end

  // Fold the index into 0..64, look up the magnitude and apply the offset.
  always_comb begin
    w_idx = {1'b0, w_fine};
    if (w_mirror) begin
      w_idx = 7'd64 - {1'b0, w_fine};
    end
    w_mag = quarter_sine(w_idx);
    if (w_negate) begin
      w_sum = {1'b0, OFFSET} - {2'b00, w_mag};
    end else begin
      w_sum = {1'b0, OFFSET} + {2'b00, w_mag};
    end
    // 128 +/- 127 always lands in 1..255, so the ninth bit stays clear.
    assert (w_sum[8] == 1'b0);
    o_sample = w_sum[7:0];
  end

endmodule

// File: rtl/dds.sv
// Free-running direct digital synthesiser: a phase accumulator advances by
// a fixed tuning word every clock and its top 8 bits address a sine table.
// The output register samples the table using the pre-update phase, so the
// first edge after reset re-outputs the 0x80 midpoint.
module dds
  import dds_pkg::*;
#(
  parameter int                   ACC_WIDTH = 32,
  parameter logic [ACC_WIDTH-1:0] FTW       = 32'h0100_0000,
  parameter int                   OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [OUT_WIDTH-1:0] dds_out
);

  logic [ACC_WIDTH-1:0]  r_phase;
  logic [OUT_WIDTH-1:0]  r_out;
  logic [LUT_ADDR_W-1:0] w_addr;
  logic [7:0]            w_sample;

  // Only the top bits address the table; lower bits are plain truncation.
  assign w_addr = r_phase[ACC_WIDTH-1 -: LUT_ADDR_W];

  dds_sine_rom u_rom (
    .i_addr   (w_addr),
    .o_sample (w_sample)
  );

  // Phase accumulator: wraps modulo 2^ACC_WIDTH with no overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + FTW;
    end
  end

  // Output register: one-cycle registered sample of the current phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= OFFSET;
    end else begin
      r_out <= w_sample;
    end
  end

  assign dds_out = r_out;

endmodule

// File: tb/tb_dds.sv
// Self-checking bench for dds: a formula-based sine model checked every
// cycle, plus literal anchor values on selected edges.
module tb_dds;

  localparam longint FTW_A = 64'h0100_0000;
  localparam longint FTW_B = 64'h0200_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dds_out;
  logic [7:0] dds_out2;

  int checks = 0;
  int errors = 0;
  int n = 0;  // rising edges since reset release

  logic [7:0]  async_val;
  logic [31:0] async_phase;
  int          async_req  = 0;
  int          async_done = 0;
  bit          model_pinned = 1'b0;
  logic [7:0]  first_seq [1:256];

  // Anchor table: edge number, which instance (0 = default, 1 = FTW_B), value.
  int pin_n   [9] = '{1, 2, 65, 129, 193, 257, 1000, 33, 97};
  int pin_dut [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
  int pin_val [9] = '{8'h80, 8'h83, 8'hFF, 8'h80, 8'h01, 8'h80, 8'h37, 8'hFF, 8'h01};

  always #5 clk = ~clk;

  dds dut (
    .clk     (clk),
    .rst     (rst),
    .dds_out (dds_out)
  );

  dds #(.FTW(32'h0200_0000)) dut2 (
    .clk     (clk),
    .rst     (rst),
    .dds_out (dds_out2)
  );

  // Edge counter since release; cleared asynchronously like the design.
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  // LUT(k) = 128 + round(127*sin(2*pi*k/256)).
  function automatic int lut_ref(int k);
    real v;
    v = 127.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 256.0);
    if (v >= 0.0) return 128 + $rtoi(v + 0.5);
    else          return 128 - $rtoi(-v + 0.5);
  endfunction

  // Edge e after release drives LUT(((e-1)*FTW mod 2^32) >> 24).
  function automatic int exp_at(int e, longint ftw);
    longint ph;
    if (e < 1) return 8'h80;
    ph = (longint'(e - 1) * ftw) & 64'hFFFF_FFFF;
    return lut_ref(int'(ph >> 24));
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=0x%0h expected=0x%0h", name, n, got, exp);
    end
  endtask

  // Single compare process: samples on the falling edge, away from clk rise.
  always @(negedge clk) begin
    if (!model_pinned) begin
      check("model_lut0",   lut_ref(0),   8'h80);
      check("model_lut1",   lut_ref(1),   8'h83);
      check("model_lut64",  lut_ref(64),  8'hFF);
      check("model_lut192", lut_ref(192), 8'h01);
      check("model_lut231", lut_ref(231), 8'h37);
      model_pinned = 1'b1;
    end
    if (rst) begin
      check("rst_out",   int'(dds_out),  8'h80);
      check("rst_out2",  int'(dds_out2), 8'h80);
      check("rst_phase", int'(dut.r_phase), 0);
    end else begin
      check("seq_a", int'(dds_out),  exp_at(n, FTW_A));
      check("seq_b", int'(dds_out2), exp_at(n, FTW_B));
      check("never_zero", int'(dds_out == 8'h00), 0);
      if (n >= 1 && n <= 256) begin
        first_seq[n] = dds_out;
      end else if (n >= 257 && n <= 512) begin
        check("wrap_repeat", int'(dds_out), int'(first_seq[n - 256]));
      end
      for (int i = 0; i < 9; i++) begin
        if (pin_n[i] == n) begin
          if (pin_dut[i] == 0) begin
            check("anchor_a", int'(dds_out), pin_val[i]);
            $display("anchor dut  edge=%0d out=0x%02h", n, dds_out);
          end else begin
            check("anchor_b", int'(dds_out2), pin_val[i]);
            $display("anchor dut2 edge=%0d out=0x%02h", n, dds_out2);
          end
        end
      end
    end
    if (async_req != async_done) begin
      check("async_rst_out",   int'(async_val),   8'h80);
      check("async_rst_phase", int'(async_phase), 0);
      async_done = async_req;
    end
  end

  // Stimulus: 4 reset cycles, 1000-edge run, async reset, restart.
  initial begin
    repeat (4) @(negedge clk);
    #1 rst = 1'b0;                 // released before the edge at 45 ns
    repeat (1000) @(negedge clk);  // t = 10040 ns, edge 1000 checked here
    $display("async reset asserted with dds_out=0x%02h", dds_out);
    #2 rst = 1'b1;                 // between edges, output currently 0x37
    #1;
    async_val   = dds_out;
    async_phase = dut.r_phase;
    async_req   = async_req + 1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (300) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
